// File: rtl/pll_sup_pkg.sv
// -----------------------------------------------------------------------------
// pll_sup_pkg
// Shared definitions for the PLL lock supervisor.
//   state_t    : FSM state encoding, also driven onto the debug 'state' port.
//   LOSS_CNT_W : width of the saturating lock-loss event counter.
// -----------------------------------------------------------------------------
package pll_sup_pkg;

    localparam int LOSS_CNT_W = 8;

    // Codes 4..7 are unused; the FSM treats them as a request to restart
    // the PLL from scratch.
    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3
    } state_t;

endpackage

// File: rtl/pll_lock_supervisor_sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchroniser for a single asynchronous level signal.
// Ports:
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, both flops clear to 0
//   d     : asynchronous input
//   q     : synchronised output (two clk cycles of latency)
// -----------------------------------------------------------------------------
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor
// Drives the rPLL RESET pin, qualifies the asynchronous LOCK output and
// sequences the system reset from it. Runs on the PLL reference clock so it
// keeps working while the PLL output is absent.
//
// Sequence: RESET_PLL (PLL held in reset) -> WAIT_LOCK (bounded wait for lock)
// -> STABLE (lock must stay high for a full window) -> RUN (system released).
// A lock drop in RUN longer than the glitch filter restarts the sequence.
//
// Ports:
//   clk       : PLL reference clock (same net as PLL clkin)
//   rst_n     : asynchronous active-low reset
//   pll_lock  : raw PLL LOCK, asynchronous to clk
//   pll_reset : PLL RESET, active high
//   sys_rst_n : active-low system reset (consumers re-synchronise it)
//   ready     : high only while in RUN
//   lock_lost : one-cycle pulse when a lock loss is accepted in RUN
//   pll_err   : sticky, MAX_RETRY consecutive lock timeouts seen
//   loss_cnt  : number of lock-loss events, saturating
//   state     : encoded FSM state for debug
//
// Valid/ready: there is no handshake interface; every output is a registered
// level or pulse and may be sampled on any clk edge.
// -----------------------------------------------------------------------------
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 100000,
    parameter int STABLE_CYCLES = 1024,
    parameter int GLITCH_CYCLES = 4,
    parameter int MAX_RETRY     = 3,
    parameter int CNT_W         = 17
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pll_lock,
    output logic                  pll_reset,
    output logic                  sys_rst_n,
    output logic                  ready,
    output logic                  lock_lost,
    output logic                  pll_err,
    output logic [LOSS_CNT_W-1:0] loss_cnt,
    output logic [2:0]            state
);

    localparam int RETRY_W  = 8;
    localparam int GLITCH_W = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES) : 1;

    // Terminal counts: each phase ends on the cycle its counter hits N-1.
    localparam logic [CNT_W-1:0]    RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]    TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]    STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [GLITCH_W-1:0] GLITCH_LAST = GLITCH_W'(GLITCH_CYCLES - 1);
    localparam logic [RETRY_W-1:0]  RETRY_ERR   = RETRY_W'(MAX_RETRY);

    logic                  w_lk;
    logic [RETRY_W-1:0]    w_retry_inc;

    state_t                r_state;
    logic [CNT_W-1:0]      r_timer;
    logic [RETRY_W-1:0]    r_retry;
    logic [GLITCH_W-1:0]   r_glitch;
    logic                  r_pll_reset;
    logic                  r_sys_rst_n;
    logic                  r_ready;
    logic                  r_lock_lost;
    logic                  r_pll_err;
    logic [LOSS_CNT_W-1:0] r_loss_cnt;

    sync2 u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_lock),
        .q     (w_lk)
    );

    assign w_retry_inc = r_retry + 1'b1;

    // Outputs are assigned alongside the state transition that implies them,
    // so each output register always agrees with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RESET_PLL;
            r_timer     <= '0;
            r_retry     <= '0;
            r_glitch    <= '0;
            r_pll_reset <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_ready     <= 1'b0;
            r_lock_lost <= 1'b0;
            r_pll_err   <= 1'b0;
            r_loss_cnt  <= '0;
        end else begin
            r_lock_lost <= 1'b0;

            case (r_state)
                ST_RESET_PLL: begin
                    r_pll_reset <= 1'b1;
                    r_sys_rst_n <= 1'b0;
                    r_ready     <= 1'b0;
                    r_glitch    <= '0;
                    if (r_timer == RST_LAST) begin
                        r_state     <= ST_WAIT_LOCK;
                        r_timer     <= '0;
                        r_pll_reset <= 1'b0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                ST_WAIT_LOCK: begin
                    // Lock seen on the timeout cycle still counts as lock.
                    if (w_lk) begin
                        r_state <= ST_STABLE;
                        r_timer <= '0;
                    end else if (r_timer == TO_LAST) begin
                        r_state     <= ST_RESET_PLL;
                        r_timer     <= '0;
                        r_pll_reset <= 1'b1;
                        // Retry saturates rather than wrapping so a long
                        // failure streak can never look like a fresh start.
                        if (r_retry != '1) begin
                            r_retry <= w_retry_inc;
                        end
                        if ((r_retry != '1) && (w_retry_inc == RETRY_ERR)) begin
                            r_pll_err <= 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                ST_STABLE: begin
                    // Any low sample restarts qualification with a fresh
                    // timeout; it is not a failed attempt.
                    if (!w_lk) begin
                        r_state <= ST_WAIT_LOCK;
                        r_timer <= '0;
                    end else if (r_timer == STABLE_LAST) begin
                        r_state     <= ST_RUN;
                        r_timer     <= '0;
                        r_retry     <= '0;
                        r_glitch    <= '0;
                        r_sys_rst_n <= 1'b1;
                        r_ready     <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                ST_RUN: begin
                    if (w_lk) begin
                        r_glitch <= '0;
                    end else if (r_glitch == GLITCH_LAST) begin
                        // This low sample completes a full glitch window.
                        r_state     <= ST_RESET_PLL;
                        r_timer     <= '0;
                        r_glitch    <= '0;
                        r_lock_lost <= 1'b1;
                        r_pll_reset <= 1'b1;
                        r_sys_rst_n <= 1'b0;
                        r_ready     <= 1'b0;
                        if (r_loss_cnt != '1) begin
                            r_loss_cnt <= r_loss_cnt + 1'b1;
                        end
                    end else begin
                        r_glitch <= r_glitch + 1'b1;
                    end
                end

                default: begin
                    r_state     <= ST_RESET_PLL;
                    r_timer     <= '0;
                    r_glitch    <= '0;
                    r_pll_reset <= 1'b1;
                    r_sys_rst_n <= 1'b0;
                    r_ready     <= 1'b0;
                end
            endcase
        end
    end

    assign pll_reset = r_pll_reset;
    assign sys_rst_n = r_sys_rst_n;
    assign ready     = r_ready;
    assign lock_lost = r_lock_lost;
    assign pll_err   = r_pll_err;
    assign loss_cnt  = r_loss_cnt;
    assign state     = r_state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
module tb_pll_lock_supervisor;

    localparam int RST_C = 4;
    localparam int TO_C  = 20;
    localparam int STB_C = 8;
    localparam int GL_C  = 3;
    localparam int MAXR  = 2;
    // pll_lock changed just after edge n is first acted on at edge n+3
    // (two synchroniser flops, then the state register).
    localparam int SYNC_LAT = 3;
    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_lock = 1'b0;
    logic       pll_reset;
    logic       sys_rst_n;
    logic       ready;
    logic       lock_lost;
    logic       pll_err;
    logic [7:0] loss_cnt;
    logic [2:0] state;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int model_total = 0;
    logic [W-1:0] exp_q[$];

    pll_lock_supervisor #(
        .RST_CYCLES    (RST_C),
        .LOCK_TIMEOUT  (TO_C),
        .STABLE_CYCLES (STB_C),
        .GLITCH_CYCLES (GL_C),
        .MAX_RETRY     (MAXR),
        .CNT_W         (17)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pll_lock  (pll_lock),
        .pll_reset (pll_reset),
        .sys_rst_n (sys_rst_n),
        .ready     (ready),
        .lock_lost (lock_lost),
        .pll_err   (pll_err),
        .loss_cnt  (loss_cnt),
        .state     (state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".pll_reset"}, 32'(pll_reset), 32'd1);
        check({tag, ".sys_rst_n"}, 32'(sys_rst_n), 32'd0);
        check({tag, ".ready"},     32'(ready),     32'd0);
        check({tag, ".lock_lost"}, 32'(lock_lost), 32'd0);
        check({tag, ".pll_err"},   32'(pll_err),   32'd0);
        check({tag, ".loss_cnt"},  32'(loss_cnt),  32'd0);
        check({tag, ".state"},     32'(state),     32'd0);
    endtask

    task automatic wait_ready(input int budget, output int t);
        t = 0;
        while (!ready && t < budget) begin
            step();
            t++;
        end
        if (!ready) begin
            check("ready_timeout", 32'(ready), 32'd1);
            t = -1;
        end
    endtask

    // Drop lock in RUN and return once the PLL reset pulse has finished,
    // i.e. on the first WAIT_LOCK cycle.
    task automatic force_loss_to_wait();
        int b;
        pll_lock = 1'b0;
        b = 0;
        while (!pll_reset && b < 30) begin step(); b++; end
        if (!pll_reset) check("loss_timeout", 32'(pll_reset), 32'd1);
        b = 0;
        while (pll_reset && b < 30) begin step(); b++; end
        if (pll_reset) check("reset_fall_timeout", 32'(pll_reset), 32'd0);
    endtask

    // Scoreboard side: one accepted loss event in the reference model.
    task automatic model_loss();
        model_total++;
        exp_q.push_back((model_total > 255) ? W'(255) : W'(model_total));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int hi, t, d, len, first, pulses, notready, rise, b, exp_t;
        int dlist[4];
        dlist = '{18, 18, 17, 0};

        // Reset values
        steps(2);
        check_reset_values("por");

        // Clean lock
        rst_n = 1'b1;
        hi = 0;
        while (pll_reset && hi < 50) begin hi++; step(); end
        check("clean.rst_width", hi, RST_C);
        check("clean.state_wait", 32'(state), 32'd1);
        steps(5);
        pll_lock = 1'b1;
        rise = cyc;
        wait_ready(60, t);
        check("clean.release_lat", cyc - rise, SYNC_LAT + STB_C);
        check("clean.sys_rst_n", 32'(sys_rst_n), 32'd1);
        check("clean.state_run", 32'(state), 32'd3);
        check("clean.loss_cnt", 32'(loss_cnt), 32'd0);

        // Directed 2-cycle dip: filtered
        pll_lock = 1'b0;
        steps(2);
        pll_lock = 1'b1;
        pulses = 0; notready = 0;
        repeat (8) begin
            step();
            if (lock_lost) pulses++;
            if (!ready) notready++;
        end
        check("dip2.pulses", pulses, 0);
        check("dip2.notready", notready, 0);

        // Directed 3-cycle dip: accepted at edge n+SYNC_LAT+GL_C-1
        pll_lock = 1'b0;
        steps(SYNC_LAT + GL_C - 2);
        check("dip3.early", 32'(lock_lost), 32'd0);
        step();
        model_loss();
        check("dip3.lock_lost", 32'(lock_lost), 32'd1);
        check("dip3.loss_cnt", 32'(loss_cnt), 32'(exp_q.pop_front()));
        check("dip3.sys_rst_n", 32'(sys_rst_n), 32'd0);
        check("dip3.state", 32'(state), 32'd0);
        pll_lock = 1'b1;
        step();
        check("dip3.one_pulse", 32'(lock_lost), 32'd0);
        wait_ready(60, t);
        check("dip3.recover", 32'(ready), 32'd1);

        // Random / boundary lock delay after a fresh PLL reset
        for (int i = 0; i < 10; i++) begin
            d = (i < 4) ? dlist[i] : int'($urandom_range(0, 22));
            force_loss_to_wait();
            model_loss();
            steps(d);
            pll_lock = 1'b1;
            rise = cyc;
            wait_ready(80, t);
            if (SYNC_LAT + d <= TO_C)
                exp_t = SYNC_LAT + STB_C;
            else
                exp_t = TO_C + RST_C + 1 + STB_C - d;
            check("delay.latency", cyc - rise, exp_t);
            check("delay.pll_err", 32'(pll_err), 32'd0);
            check("delay.loss_cnt", 32'(loss_cnt), 32'(exp_q.pop_front()));
        end

        // Chatter during STABLE
        force_loss_to_wait();
        model_loss();
        steps(2);
        pll_lock = 1'b1;
        steps(5);
        pll_lock = 1'b0;
        step();
        pll_lock = 1'b1;
        rise = cyc;
        step();
        check("chatter.still_stable", 32'(state), 32'd2);
        step();
        check("chatter.back_to_wait", 32'(state), 32'd1);
        step();
        check("chatter.restable", 32'(state), 32'd2);
        wait_ready(60, t);
        check("chatter.release_lat", cyc - rise, SYNC_LAT + STB_C);
        check("chatter.pll_err", 32'(pll_err), 32'd0);
        check("chatter.loss_cnt", 32'(loss_cnt), 32'(exp_q.pop_front()));

        // Random dips in RUN
        for (int i = 0; i < 14; i++) begin
            len = $urandom_range(1, 5);
            pll_lock = 1'b0;
            first = -1; pulses = 0; notready = 0;
            for (int k = 1; k <= len + GL_C + 4; k++) begin
                step();
                if (k == len) pll_lock = 1'b1;
                if (lock_lost) begin
                    pulses++;
                    if (first < 0) first = k;
                end
                if (!ready) notready++;
            end
            if (len >= GL_C) begin
                model_loss();
                check("rdip.pulses", pulses, 1);
                check("rdip.edge", first, SYNC_LAT + GL_C - 1);
            end else begin
                exp_q.push_back((model_total > 255) ? W'(255) : W'(model_total));
                check("rdip.pulses", pulses, 0);
                check("rdip.notready", notready, 0);
            end
            wait_ready(80, t);
            check("rdip.loss_cnt", 32'(loss_cnt), 32'(exp_q.pop_front()));
        end

        // Saturation of loss_cnt
        while (model_total < 260) begin
            pll_lock = 1'b0;
            b = 0;
            while (!lock_lost && b < 20) begin step(); b++; end
            if (!lock_lost) check("sat.lost_timeout", 32'(lock_lost), 32'd1);
            model_loss();
            check("sat.loss_cnt", 32'(loss_cnt), 32'(exp_q.pop_front()));
            pll_lock = 1'b1;
            wait_ready(80, t);
        end
        check("sat.final", 32'(loss_cnt), 32'd255);

        // Asynchronous reset in RUN (mid-cycle, no clock edge)
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        pll_lock = 1'b0;
        #1;
        check_reset_values("arst_run");

        // No lock: periodic PLL reset, sticky error after MAXR timeouts
        step();
        rst_n = 1'b1;
        for (int s = 0; s < 3 * (RST_C + TO_C); s++) begin
            check("nolock.pll_reset", 32'(pll_reset), 32'((s % (RST_C + TO_C)) < RST_C));
            check("nolock.pll_err", 32'(pll_err), 32'(s >= MAXR * (RST_C + TO_C)));
            check("nolock.sys_rst_n", 32'(sys_rst_n), 32'd0);
            step();
        end
        steps(RST_C + 2);
        check("nolock.in_wait", 32'(state), 32'd1);
        check("nolock.err_sticky", 32'(pll_err), 32'd1);

        // Asynchronous reset in WAIT_LOCK clears pll_err
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_values("arst_wait");

        // pll_err survives a later successful lock
        step();
        rst_n = 1'b1;
        steps(MAXR * (RST_C + TO_C) + 2);
        check("errlock.err_set", 32'(pll_err), 32'd1);
        pll_lock = 1'b1;
        wait_ready(80, t);
        check("errlock.ready", 32'(ready), 32'd1);
        check("errlock.err_kept", 32'(pll_err), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
